gpio_checker: RTL and testbench
===============================

# gpio_checker

Synthesizable self-test monitor that sits on the CPU `gpio` output and checks it against a programmed sequence of expected values, each sampled a programmed number of cycles after the previous check. It replaces fixed-offset bench checks with a reusable hardware block usable in simulation and on-chip. Width, table depth, delay range and stop-on-fail behaviour are parametrised; per-bit masking and error counting are provided.

## Interface
- `DATA_WIDTH`, 32: width of the observed bus and of the expect/mask words.
- `ADDR_WIDTH`, 5: table holds 2**ADDR_WIDTH entries.
- `DELAY_WIDTH`, 8: width of the per-entry delay field.
- `STOP_ON_FAIL`, 1: 1 ends the run at the first mismatch; 0 runs all entries and counts errors.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `gpio`  in  DATA_WIDTH  observed bus.
- `cfg_we`  in  1  table write strobe.
- `cfg_addr`  in  ADDR_WIDTH  table entry index.
- `cfg_delay`  in  DELAY_WIDTH  cycles from the previous check, or from start, to this check.
- `cfg_expect`  in  DATA_WIDTH  expected value.
- `cfg_mask`  in  DATA_WIDTH  1 = bit compared, 0 = don't care.
- `start`  in  1  single-cycle run request.
- `count`  in  ADDR_WIDTH+1  number of entries to run, sampled with `start`.
- `busy`  out  1  run in progress.
- `done`  out  1  run finished; level.
- `pass`  out  1  valid when `done`; 1 = no mismatches.
- `err_count`  out  ADDR_WIDTH+1  mismatches in the last run.
- `fail_index`  out  ADDR_WIDTH  entry index of the first mismatch.
- `fail_actual`  out  DATA_WIDTH  `gpio` value captured at the first mismatch.

## Operation
- States are IDLE, WAIT and DONE. Reset enters IDLE. Table contents are not reset.
- Table writes take effect at the clock edge when `cfg_we`=1 and the state is not WAIT. `cfg_we` during WAIT is ignored.
- `start` in IDLE or DONE behaves as follows:
  - `count`=0: go directly to DONE with `pass`=1 and `err_count`=0.
  - Otherwise: latch `count`, set index to 0, load the delay counter with entry 0 delay, clear `err_count`, `done`, `fail_index` and `fail_actual`, and go to WAIT.
- `start` during WAIT is ignored.
- In WAIT the counter decrements each cycle. A check happens on the edge where the counter equals 1.
  - A delay field of 0 is treated as 1.
- Check rule: mismatch when ((`gpio` ^ expect) & mask) != 0. `gpio` is sampled at the check edge.
- On the first mismatch of a run, capture `fail_index` and `fail_actual`. Later mismatches only increment `err_count`. `err_count` saturates at all-ones.
- With `STOP_ON_FAIL`=1, a mismatch moves the state to DONE on that edge.
- After a check at index = `count`-1, go to DONE. Otherwise increment the index and load the next entry's delay.
- Table read is combinational from the current index. A write to the active entry during a run cannot happen, because writes are blocked in WAIT.
- `pass` = (`err_count`==0), registered on entry to DONE.
- DONE holds all results until the next `start` or reset.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_index`=0, `fail_actual`=0, state IDLE.
- `start` is sampled at edge E0, and `busy` rises after E0. Entry 0 is checked at edge E0+d0. Entry i is checked at edge E(i-1)+di, where E(i-1) is the check edge of the previous entry.
- `done` rises, and `busy` falls, after the final check edge. Both outputs and `err_count` update on that same edge.
- Run with `count`=0: `done`=1 and `pass`=1 one cycle after `start`, and `busy` never rises.
- Reset asserted mid-run: all outputs clear immediately (asynchronously) and the state returns to IDLE. No partial results are retained.
- A `start` in the same cycle as `cfg_we` in IDLE is legal: the write completes and the run reads the new contents.

## Test plan
- Program entries {delay 3, expect FFFFFFFF, mask all}, {1, 00000001, all}, {1, 00000006, all}. Drive matching `gpio` on those edges, `count`=3 → `done` 5 cycles after `start`, `pass`=1, `err_count`=0.
- Same table, with `gpio`=00000005 at the entry 1 check, `STOP_ON_FAIL`=1 → `done` immediately after the entry 1 check edge, `pass`=0, `fail_index`=1, `fail_actual`=00000005, `err_count`=1.
- `STOP_ON_FAIL`=0, with mismatches at entries 0 and 2 → run completes all 3 checks, `err_count`=2, `fail_index`=0.
- Mask 0000FF00 with expect 00001200, `gpio`=ABCD12EF → check passes. Also cover delay=0 executing as 1 and `count`=0 giving immediate `pass`.
- Assert `cfg_we` and `start` mid-run, then assert `reset` mid-run → table and run are unaffected by the write and start. Reset clears all outputs asynchronously, and a subsequent `start` runs cleanly.

Source files
------------

// File: rtl/gpio_checker.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_checker
//  Description : Self-test monitor for a GPIO bus. Compares the observed bus
//                against a programmed table of {delay, expect, mask} entries,
//                each checked a programmed number of cycles after the last,
//                and reports pass/fail, error count and first-failure info.
//  Revision    : 1.0  initial release
// ============================================================================
module gpio_checker #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int DELAY_WIDTH  = 8,
    parameter int STOP_ON_FAIL = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   gpio,
    input  logic                    cfg_we,
    input  logic [ADDR_WIDTH-1:0]   cfg_addr,
    input  logic [DELAY_WIDTH-1:0]  cfg_delay,
    input  logic [DATA_WIDTH-1:0]   cfg_expect,
    input  logic [DATA_WIDTH-1:0]   cfg_mask,
    input  logic                    start,
    input  logic [ADDR_WIDTH:0]     count,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [ADDR_WIDTH:0]     err_count,
    output logic [ADDR_WIDTH-1:0]   fail_index,
    output logic [DATA_WIDTH-1:0]   fail_actual
);

    localparam int CW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] c_addr_zero = '0;

    // Table storage (deliberately not reset)
    logic [DELAY_WIDTH-1:0] r_tbl_delay  [0:DEPTH-1];
    logic [DATA_WIDTH-1:0]  r_tbl_expect [0:DEPTH-1];
    logic [DATA_WIDTH-1:0]  r_tbl_mask   [0:DEPTH-1];

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [CW-1:0]          r_index;
    logic [CW-1:0]          r_count;
    logic [DELAY_WIDTH-1:0] r_delay_cnt;
    logic [CW-1:0]          r_err_count;
    logic [ADDR_WIDTH-1:0]  r_fail_index;
    logic [DATA_WIDTH-1:0]  r_fail_actual;
    logic                   r_pass;

    logic                   w_wr_en;
    logic                   w_start;
    logic [ADDR_WIDTH-1:0]  w_rd_addr;
    logic                   w_check;
    logic                   w_mismatch;
    logic                   w_last;
    logic                   w_stop;
    logic [CW-1:0]          w_err_next;
    logic [CW-1:0]          w_index_next;
    logic [DELAY_WIDTH-1:0] w_next_delay_raw;
    logic [DELAY_WIDTH-1:0] w_start_delay_raw;

    // A programmed delay of zero behaves exactly like a delay of one
    function automatic logic [DELAY_WIDTH-1:0] f_nonzero(input logic [DELAY_WIDTH-1:0] d);
        return (d == '0) ? DELAY_WIDTH'(1) : d;
    endfunction

    assign w_wr_en    = cfg_we && (r_state != S_WAIT);
    assign w_start    = start && (r_state != S_WAIT);
    assign w_rd_addr  = r_index[ADDR_WIDTH-1:0];
    assign w_check    = (r_state == S_WAIT) && (r_delay_cnt == DELAY_WIDTH'(1));
    assign w_mismatch = |((gpio ^ r_tbl_expect[w_rd_addr]) & r_tbl_mask[w_rd_addr]);
    assign w_last     = (r_index == (r_count - CW'(1)));
    assign w_stop     = w_check && (w_last || (w_mismatch && (STOP_ON_FAIL != 0)));
    assign w_err_next = (w_mismatch && (r_err_count != '1)) ? (r_err_count + CW'(1)) : r_err_count;
    assign w_index_next     = r_index + CW'(1);
    assign w_next_delay_raw = r_tbl_delay[w_index_next[ADDR_WIDTH-1:0]];
    // A start coinciding with a write to entry 0 must see the new delay
    assign w_start_delay_raw = (cfg_we && (cfg_addr == c_addr_zero)) ? cfg_delay
                                                                     : r_tbl_delay[c_addr_zero];

    // Table write port, blocked while a run is active
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_tbl_delay[cfg_addr]  <= cfg_delay;
            r_tbl_expect[cfg_addr] <= cfg_expect;
            r_tbl_mask[cfg_addr]   <= cfg_mask;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next = (count == '0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_stop) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (r_state == S_WAIT);
        done = (r_state == S_DONE);
    end

    // Run datapath: sequencing, delay countdown, error capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_index       <= '0;
            r_count       <= '0;
            r_delay_cnt   <= '0;
            r_err_count   <= '0;
            r_fail_index  <= '0;
            r_fail_actual <= '0;
            r_pass        <= 1'b0;
        end else if (w_start) begin
            r_err_count   <= '0;
            r_fail_index  <= '0;
            r_fail_actual <= '0;
            if (count == '0) begin
                r_pass <= 1'b1;
            end else begin
                r_pass      <= 1'b0;
                r_count     <= count;
                r_index     <= '0;
                r_delay_cnt <= f_nonzero(w_start_delay_raw);
            end
        end else if (w_check) begin
            r_err_count <= w_err_next;
            if (w_mismatch && (r_err_count == '0)) begin
                r_fail_index  <= w_rd_addr;
                r_fail_actual <= gpio;
            end
            if (w_stop) begin
                r_pass <= (w_err_next == '0);
            end else begin
                r_index     <= w_index_next;
                r_delay_cnt <= f_nonzero(w_next_delay_raw);
            end
        end else if (r_state == S_WAIT) begin
            r_delay_cnt <= r_delay_cnt - DELAY_WIDTH'(1);
        end
    end

    assign pass        = r_pass;
    assign err_count   = r_err_count;
    assign fail_index  = r_fail_index;
    assign fail_actual = r_fail_actual;

endmodule
`default_nettype wire

// File: tb/tb_gpio_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_checker
//  Description : Self-checking bench for gpio_checker. Two instances (stop on
//                first failure / run all entries) share stimulus; a schedule
//                based reference model is compared against both every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gpio_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] gpio;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [7:0]  cfg_delay;
    logic [31:0] cfg_expect;
    logic [31:0] cfg_mask;
    logic        start;
    logic [5:0]  count;

    logic        s_busy, s_done, s_pass;
    logic [5:0]  s_err;
    logic [4:0]  s_fidx;
    logic [31:0] s_fact;
    logic        n_busy, n_done, n_pass;
    logic [5:0]  n_err;
    logic [4:0]  n_fidx;
    logic [31:0] n_fact;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    always #5 clk = ~clk;

    gpio_checker #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DELAY_WIDTH(8), .STOP_ON_FAIL(1)) u_sof (
        .clk(clk), .reset(reset), .gpio(gpio),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_delay(cfg_delay),
        .cfg_expect(cfg_expect), .cfg_mask(cfg_mask),
        .start(start), .count(count),
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err),
        .fail_index(s_fidx), .fail_actual(s_fact)
    );

    gpio_checker #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DELAY_WIDTH(8), .STOP_ON_FAIL(0)) u_all (
        .clk(clk), .reset(reset), .gpio(gpio),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_delay(cfg_delay),
        .cfg_expect(cfg_expect), .cfg_mask(cfg_mask),
        .start(start), .count(count),
        .busy(n_busy), .done(n_done), .pass(n_pass), .err_count(n_err),
        .fail_index(n_fidx), .fail_actual(n_fact)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (index 0: stop-on-fail, 1: run all) ----
    bit          m_busy [2];
    bit          m_done [2];
    bit          m_pass [2];
    int          m_err  [2];
    int          m_idx  [2];
    int          m_cnt  [2];
    int          m_fidx [2];
    logic [31:0] m_fact [2];
    longint      m_next [2];
    longint      cyc = 0;
    int          t_delay [2][32];
    logic [31:0] t_exp   [2][32];
    logic [31:0] t_mask  [2][32];

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    // Model: each check is scheduled at an absolute edge number
    always @(posedge clk or posedge reset) begin : p_model
        bit mis;
        int e;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_busy[k] = 0; m_done[k] = 0; m_pass[k] = 0;
                m_err[k] = 0; m_fidx[k] = 0; m_fact[k] = '0;
                m_idx[k] = 0; m_cnt[k] = 0; m_next[k] = 0;
            end
        end else begin
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (!m_busy[k] && cfg_we) begin
                    t_delay[k][cfg_addr] = int'(cfg_delay);
                    t_exp[k][cfg_addr]   = cfg_expect;
                    t_mask[k][cfg_addr]  = cfg_mask;
                end
                if (m_busy[k]) begin
                    if (cyc == m_next[k]) begin
                        e = m_idx[k] % 32;
                        mis = ((gpio ^ t_exp[k][e]) & t_mask[k][e]) != 32'h0;
                        if (mis) begin
                            if (m_err[k] == 0) begin
                                m_fidx[k] = e;
                                m_fact[k] = gpio;
                            end
                            if (m_err[k] < 63) m_err[k]++;
                        end
                        if ((mis && k == 0) || m_idx[k] == m_cnt[k] - 1) begin
                            m_busy[k] = 0;
                            m_done[k] = 1;
                            m_pass[k] = (m_err[k] == 0);
                        end else begin
                            m_idx[k]++;
                            m_next[k] = cyc + eff(t_delay[k][m_idx[k] % 32]);
                        end
                    end
                end else if (start) begin
                    m_err[k] = 0; m_fidx[k] = 0; m_fact[k] = '0;
                    if (count == 6'd0) begin
                        m_done[k] = 1;
                        m_pass[k] = 1;
                    end else begin
                        m_busy[k] = 1;
                        m_done[k] = 0;
                        m_idx[k]  = 0;
                        m_cnt[k]  = int'(count);
                        m_next[k] = cyc + eff(t_delay[k][0]);
                    end
                end
            end
        end
    end

    task automatic cmp(input int k, input logic b, input logic d, input logic p,
                       input logic [5:0] er, input logic [4:0] fi, input logic [31:0] fa);
        string n;
        n = (k == 0) ? "sof" : "all";
        chk({n, ".busy"}, 64'(b), 64'(m_busy[k]));
        chk({n, ".done"}, 64'(d), 64'(m_done[k]));
        chk({n, ".err_count"}, 64'(er), 64'(m_err[k]));
        if (m_done[k]) chk({n, ".pass"}, 64'(p), 64'(m_pass[k]));
        if (m_done[k] && !m_pass[k]) begin
            chk({n, ".fail_index"}, 64'(fi), 64'(m_fidx[k]));
            chk({n, ".fail_actual"}, 64'(fa), 64'(m_fact[k]));
        end
    endtask

    // Compare both instances against the model away from the active edge
    always @(negedge clk) begin
        if (run_cmp && !reset) begin
            cmp(0, s_busy, s_done, s_pass, s_err, s_fidx, s_fact);
            cmp(1, n_busy, n_done, n_pass, n_err, n_fidx, n_fact);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [31:0] g);
        gpio = g;
        @(negedge clk);
    endtask

    task automatic prog(input logic [4:0] a, input logic [7:0] d,
                        input logic [31:0] ex, input logic [31:0] mk);
        cfg_we = 1'b1; cfg_addr = a; cfg_delay = d; cfg_expect = ex; cfg_mask = mk;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic run_start(input logic [5:0] c);
        start = 1'b1;
        count = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; gpio = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_delay = '0;
        cfg_expect = '0; cfg_mask = '0; start = 1'b0; count = '0;
        repeat (3) @(negedge clk);
        chk("rst.busy", 64'(s_busy), 64'(0));
        chk("rst.done", 64'(s_done), 64'(0));
        chk("rst.pass", 64'(s_pass), 64'(0));
        chk("rst.err_count", 64'(s_err), 64'(0));
        chk("rst.fail_index", 64'(s_fidx), 64'(0));
        chk("rst.fail_actual", 64'(s_fact), 64'(0));
        reset = 1'b0;
        run_cmp = 1'b1;

        prog(5'd0, 8'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        prog(5'd1, 8'd1, 32'h0000_0001, 32'hFFFF_FFFF);
        prog(5'd2, 8'd1, 32'h0000_0006, 32'hFFFF_FFFF);

        // All entries match: done five cycles after start
        run_start(6'd3);
        drive(32'h0); drive(32'h0); drive(32'hFFFF_FFFF); drive(32'h1);
        chk("t1.done_early", 64'(s_done), 64'(0));
        chk("t1.busy", 64'(s_busy), 64'(1));
        drive(32'h6);
        chk("t1.done", 64'(s_done), 64'(1));
        chk("t1.pass", 64'(s_pass), 64'(1));
        chk("t1.err_count", 64'(n_err), 64'(0));
        drive(32'h0);

        // Mismatch at entry 1
        run_start(6'd3);
        drive(32'h0); drive(32'h0); drive(32'hFFFF_FFFF); drive(32'h5);
        chk("t2.sof_done", 64'(s_done), 64'(1));
        chk("t2.sof_pass", 64'(s_pass), 64'(0));
        chk("t2.sof_fail_index", 64'(s_fidx), 64'(1));
        chk("t2.sof_fail_actual", 64'(s_fact), 64'(32'h5));
        chk("t2.sof_err_count", 64'(s_err), 64'(1));
        chk("t2.all_busy", 64'(n_busy), 64'(1));
        drive(32'h6);
        chk("t2.all_done", 64'(n_done), 64'(1));

        // Mismatches at entries 0 and 2
        run_start(6'd3);
        drive(32'h0); drive(32'h0); drive(32'h1234_5678);
        chk("t3.sof_done", 64'(s_done), 64'(1));
        drive(32'h1); drive(32'h0);
        chk("t3.all_done", 64'(n_done), 64'(1));
        chk("t3.all_err_count", 64'(n_err), 64'(2));
        chk("t3.all_fail_index", 64'(n_fidx), 64'(0));
        chk("t3.all_fail_actual", 64'(n_fact), 64'(32'h1234_5678));

        // Write and start together; delay 0 runs as 1; masked compare
        cfg_we = 1'b1; cfg_addr = 5'd0; cfg_delay = 8'd0;
        cfg_expect = 32'h0000_1200; cfg_mask = 32'h0000_FF00;
        start = 1'b1; count = 6'd1;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0;
        drive(32'hABCD_12EF);
        chk("t4.done", 64'(s_done), 64'(1));
        chk("t4.pass", 64'(s_pass), 64'(1));
        run_start(6'd1);
        drive(32'hABCD_13EF);
        chk("t4.mask_pass", 64'(s_pass), 64'(0));
        chk("t4.mask_actual", 64'(s_fact), 64'(32'hABCD_13EF));

        // count = 0 passes immediately
        run_start(6'd0);
        chk("t5.done", 64'(s_done), 64'(1));
        chk("t5.pass", 64'(s_pass), 64'(1));
        chk("t5.busy", 64'(s_busy), 64'(0));
        drive(32'h0);

        // Writes and start during a run are ignored
        prog(5'd0, 8'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_start(6'd3);
        drive(32'h0);
        cfg_we = 1'b1; cfg_addr = 5'd1; cfg_delay = 8'd7;
        cfg_expect = 32'h0000_DEAD; cfg_mask = 32'hFFFF_FFFF;
        start = 1'b1; count = 6'd1;
        drive(32'h0);
        cfg_we = 1'b0; start = 1'b0;
        drive(32'hFFFF_FFFF); drive(32'h1); drive(32'h6);
        chk("t6.done", 64'(s_done), 64'(1));
        chk("t6.pass", 64'(s_pass), 64'(1));

        // Asynchronous reset mid-run after an error has been logged
        run_start(6'd3);
        drive(32'h0); drive(32'h0); drive(32'h0);
        chk("t7.all_err_pre", 64'(n_err), 64'(1));
        #2 reset = 1'b1;
        #1;
        chk("t7.sof_done", 64'(s_done), 64'(0));
        chk("t7.sof_fail_actual", 64'(s_fact), 64'(0));
        chk("t7.all_busy", 64'(n_busy), 64'(0));
        chk("t7.all_err", 64'(n_err), 64'(0));
        chk("t7.all_fail_index", 64'(n_fidx), 64'(0));
        #1 reset = 1'b0;
        @(negedge clk);
        run_start(6'd3);
        drive(32'h0); drive(32'h0); drive(32'hFFFF_FFFF); drive(32'h1); drive(32'h6);
        chk("t8.sof_pass", 64'(s_pass), 64'(1));
        chk("t8.all_done", 64'(n_done), 64'(1));
        chk("t8.all_pass", 64'(n_pass), 64'(1));
        drive(32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
